// File: rtl/mem_stage.sv
// mem_stage: memory-access stage. Holds one instruction from execute, runs
// the data-memory request/response for loads and stores, and presents the
// writeback pulse plus the registered forwarding pair.
// Optional build macro: MEM_STAGE_MISALIGN_TRAP_EN. When it is defined,
// misaligned H/HU/W accesses retire without touching memory and raise
// misalign_err. When it is undefined, the low address bits that lie beyond
// the access size are ignored.
module mem_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [DATA_WIDTH-1:0]    ex_opr_res,
    input  logic [DATA_WIDTH-1:0]    ex_opr_b,
    input  logic [RF_ADDR_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0]    ex_pc4,
    input  logic                     ex_rf_en,
    input  logic                     ex_dm_en,
    input  logic [1:0]               ex_wb_sel,
    input  logic [2:0]               ex_lsuop,
    output logic [RF_ADDR_WIDTH-1:0] rd_frm_mem,
    output logic [DATA_WIDTH-1:0]    opr_res_frm_mem,
    output logic                     dm_req_valid,
    input  logic                     dm_req_ready,
    output logic [DATA_WIDTH-1:0]    dm_addr,
    output logic                     dm_we,
    output logic [3:0]               dm_be,
    output logic [DATA_WIDTH-1:0]    dm_wdata,
    input  logic                     dm_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    dm_rdata,
    output logic                     wb_valid,
    output logic                     wb_rf_en,
    output logic [RF_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     misalign_err
);

    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_REQ, ST_WAIT} state_e;

    state_e                   state_q;
    logic [DATA_WIDTH-1:0]    res_q;
    logic [RF_ADDR_WIDTH-1:0] rd_q;
    logic                     rf_en_q;
    logic                     store_q;
    logic [2:0]               lsuop_q;
    logic [1:0]               off_q;

    logic                     wb_valid_q;
    logic                     wb_rf_en_q;
    logic [RF_ADDR_WIDTH-1:0] wb_rd_q;
    logic [DATA_WIDTH-1:0]    wb_data_q;
    logic [RF_ADDR_WIDTH-1:0] fwd_rd_q;
    logic [DATA_WIDTH-1:0]    fwd_data_q;
    logic                     req_valid_q;
    logic [DATA_WIDTH-1:0]    addr_q;
    logic                     we_q;
    logic [3:0]               be_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     misal_q;

    logic                     ex_accept;
    logic                     ex_is_store;
    logic                     ex_is_mem;
    logic [1:0]               ex_off;
    logic                     ex_rf_wr;
    logic                     ex_misal;
    logic [DATA_WIDTH-1:0]    ex_alu_data;
    logic [3:0]               ex_be;
    logic [DATA_WIDTH-1:0]    ex_wdata;
    logic [7:0]               ld_byte;
    logic [15:0]              ld_half;
    logic [DATA_WIDTH-1:0]    ld_data;
    logic                     ld_wr;

    assign ex_ready    = (state_q == ST_EMPTY) || (state_q == ST_HOLD);
    assign ex_accept   = ex_valid && ex_ready;
    assign ex_is_store = ex_dm_en;
    assign ex_is_mem   = ex_dm_en || (ex_wb_sel == 2'b01);
    assign ex_off      = ex_opr_res[1:0];
    assign ex_rf_wr    = ex_rf_en && (ex_rd != '0);
    assign ex_alu_data = (ex_wb_sel == 2'b10) ? ex_pc4 : ex_opr_res;
    assign ld_wr       = rf_en_q && (rd_q != '0);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign ex_misal = ex_is_mem &&
                      (((ex_lsuop[1:0] == 2'b01) && ex_off[0]) ||
                       ((ex_lsuop[1:0] == 2'b10) && (ex_off != 2'b00)));
`else
    assign ex_misal = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        ex_be    = 4'b1111;
        ex_wdata = ex_opr_b;
        case (ex_lsuop[1:0])
            2'b00: begin
                ex_be    = 4'b0001 << ex_off;
                ex_wdata = {4{ex_opr_b[7:0]}};
            end
            2'b01: begin
                ex_be    = 4'b0011 << {ex_off[1], 1'b0};
                ex_wdata = {2{ex_opr_b[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select and sign/zero extension of the returned load word.
    always_comb begin
        ld_byte = 8'h00;
        ld_data = dm_rdata;
        case (off_q)
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (lsuop_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    // Stage FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            res_q       <= '0;
            rd_q        <= '0;
            rf_en_q     <= 1'b0;
            store_q     <= 1'b0;
            lsuop_q     <= '0;
            off_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_rf_en_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            fwd_rd_q    <= '0;
            fwd_data_q  <= '0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            misal_q     <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_rf_en_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            fwd_rd_q   <= '0;
            fwd_data_q <= '0;
            misal_q    <= 1'b0;
            case (state_q)
                ST_EMPTY, ST_HOLD: begin
                    state_q <= ST_EMPTY;
                    if (ex_accept) begin
                        res_q   <= ex_opr_res;
                        rd_q    <= ex_rd;
                        rf_en_q <= ex_rf_en;
                        store_q <= ex_is_store;
                        lsuop_q <= ex_lsuop;
                        off_q   <= ex_off;
                        if (ex_misal) begin
                            state_q    <= ST_HOLD;
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= ex_rd;
                            wb_data_q  <= ex_opr_res;
                            misal_q    <= 1'b1;
                        end else if (ex_is_mem) begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                            addr_q      <= {ex_opr_res[DATA_WIDTH-1:2], 2'b00};
                            we_q        <= ex_is_store;
                            be_q        <= ex_be;
                            wdata_q     <= ex_wdata;
                        end else begin
                            state_q    <= ST_HOLD;
                            wb_valid_q <= 1'b1;
                            wb_rf_en_q <= ex_rf_wr;
                            wb_rd_q    <= ex_rd;
                            wb_data_q  <= ex_alu_data;
                            if (ex_rf_wr) begin
                                fwd_rd_q   <= ex_rd;
                                fwd_data_q <= ex_alu_data;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (dm_req_ready) begin
                        req_valid_q <= 1'b0;
                        addr_q      <= '0;
                        we_q        <= 1'b0;
                        be_q        <= '0;
                        wdata_q     <= '0;
                        if (store_q) begin
                            state_q    <= ST_HOLD;
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= res_q;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dm_rsp_valid) begin
                        state_q    <= ST_HOLD;
                        wb_valid_q <= 1'b1;
                        wb_rf_en_q <= ld_wr;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= ld_data;
                        if (ld_wr) begin
                            fwd_rd_q   <= rd_q;
                            fwd_data_q <= ld_data;
                        end
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign rd_frm_mem      = fwd_rd_q;
    assign opr_res_frm_mem = fwd_data_q;
    assign dm_req_valid    = req_valid_q;
    assign dm_addr         = addr_q;
    assign dm_we           = we_q;
    assign dm_be           = be_q;
    assign dm_wdata        = wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_rf_en        = wb_rf_en_q;
    assign wb_rd           = wb_rd_q;
    assign wb_data         = wb_data_q;
    assign misalign_err    = misal_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage core, fed by the execute stage. It registers the execute-stage result and runs the load/store transaction on the data-memory request/response interface. It returns the forwarding pair (destination register and result) that the execute stage compares against rs1/rs2, and issues one writeback pulse per retired instruction to the writeback stage.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- RF_ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  execute stage presents an instruction.
- ex_ready  output  1  the stage accepts the instruction this cycle.
- ex_opr_res  input  DATA_WIDTH  ALU result; this is the address for loads and stores.
- ex_opr_b  input  DATA_WIDTH  store data.
- ex_rd  input  RF_ADDR_WIDTH  destination register.
- ex_pc4  input  DATA_WIDTH  PC+4.
- ex_rf_en  input  1  instruction writes the register file.
- ex_dm_en  input  1  instruction is a store.
- ex_wb_sel  input  2  writeback source: 00 = ALU, 01 = memory (load), 10 = PC+4.
- ex_lsuop  input  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_frm_mem  output  RF_ADDR_WIDTH  forwarding destination; 0 when nothing is forwardable.
- opr_res_frm_mem  output  DATA_WIDTH  forwarding value.
- dm_req_valid  output  1  data-memory request.
- dm_req_ready  input  1  memory accepts the request.
- dm_addr  output  DATA_WIDTH  word-aligned address.
- dm_we  output  1  write request.
- dm_be  output  4  byte enables.
- dm_wdata  output  DATA_WIDTH  lane-replicated store data.
- dm_rsp_valid  input  1  load data valid.
- dm_rdata  input  DATA_WIDTH  load word.
- wb_valid  output  1  one-cycle retire pulse.
- wb_rf_en  output  1  register write enable; qualified by wb_valid.
- wb_rd  output  RF_ADDR_WIDTH  writeback register.
- wb_data  output  DATA_WIDTH  writeback value.
- misalign_err  output  1  misaligned-access pulse; tied 0 unless the Configuration macro is defined.

## Operation
- One-entry holding register. FSM states: EMPTY, HOLD, REQ, WAIT.
- Handshake with execute: ex_ready = (state is EMPTY or HOLD). An instruction is accepted when ex_valid and ex_ready are both high.
- Routing on accept:
  - Load (wb_sel = 01) or store (dm_en = 1) goes to REQ.
  - Any other instruction goes to HOLD.
  - With no accept, HOLD returns to EMPTY.
- HOLD:
  - wb_valid = 1.
  - wb_data is one of: the ALU result, the PC+4, or the aligned load data.
  - wb_rf_en = held rf_en; forced to 0 for stores and when rd = 0.
- REQ:
  - dm_req_valid = 1, with address, we, be and wdata stable until dm_req_ready.
  - When dm_req_ready is seen: a store goes to HOLD; a load goes to WAIT.
- WAIT:
  - When dm_rsp_valid is seen, capture the extracted load data and go to HOLD.
  - dm_rsp_valid in any other state is ignored.
- Address and store data:
  - dm_addr = {res[31:2], 2'b00}; off = res[1:0].
  - dm_be: B = 0001 << off; H = 0011 << {off[1], 1'b0}; W = 1111.
  - dm_wdata: byte replicated ×4, half replicated ×2, or the full word.
- Load extract:
  - Select the byte at lane off, or the half at lane off[1].
  - Sign-extend for B and H; zero-extend for BU and HU.
- Forwarding:
  - In HOLD with wb_rf_en = 1: rd_frm_mem = held rd and opr_res_frm_mem = wb_data.
  - Otherwise both are 0, including during load REQ/WAIT. Load-use stalls are handled upstream by ex_ready being low.
- Reset (asynchronous, any state):
  - State goes to EMPTY. All registered outputs go to 0, and dm_req_valid drops immediately.
  - ex_ready is 1 while in reset.
  - An in-flight memory response after reset is ignored.

## Timing
- ALU and jump instructions: accepted in cycle N, wb_valid in cycle N+1. Throughput is one per cycle, because HOLD accepts the next instruction.
- Store: accept in N, REQ from N+1. With ready in the same cycle, wb_valid is at N+2.
- Load: accept in N, REQ in N+1 with ready, rsp in N+2 or later. wb_valid follows the cycle after rsp, so the minimum is N+3.
- dm_rsp_valid must not arrive in the same cycle as the request handshake; the earliest is the next cycle.
- Forwarding outputs are registered and valid for exactly the HOLD cycle.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN:
  - Defined: H/HU with off[0] = 1, or W with off != 0, skips REQ and goes straight to HOLD with wb_rf_en = 0. misalign_err = 1 for that HOLD cycle, and no memory request is issued.
  - Undefined: misalign_err is tied 0. Low address bits beyond the access size are ignored (H uses off[1]; W uses off = 0).

## Test plan
- Reset: rst_n = 0 mid-load in WAIT -> all outputs 0 except ex_ready = 1; a later dm_rsp_valid produces no wb_valid.
- Back-to-back ALU ops writing x5 = 0x11 then x6 = 0x22 -> wb_valid on two consecutive cycles, with rd_frm_mem = 5 then 6 and opr_res_frm_mem matching.
- SB of 0xA5 to address 0x1003, with dm_req_ready held 0 for 3 cycles -> request stable throughout: dm_addr = 0x1000, dm_be = 1000, dm_wdata = 0xA5A5A5A5. wb_valid follows 1 cycle after ready, with wb_rf_en = 0.
- LH to address 0x2002, dm_rdata = 0x8001_1234 -> wb_data = 0xFFFF8001. LHU at the same address -> wb_data = 0x00008001.
- LW to x0 -> wb_valid = 1, wb_rf_en = 0, rd_frm_mem = 0.
- With MEM_STAGE_MISALIGN_TRAP_EN defined, LW to 0x3001 -> no dm_req_valid; misalign_err = 1 and wb_rf_en = 0 in cycle N+1.
